fir_batch_launcher: RTL and testbench

Call sequencer that sits directly upstream of the `fir` HLS component. It takes a batch command (input buffer base address plus call count) and issues one `fir` call per index over the component's start/busy interface. It collects each `returndata` over the done/stall interface and presents results, tagged with their index, on a ready/valid stream. The number of in-flight calls is bounded by result-buffer credits, so the component is never stalled in normal operation.

---
 rtl/fir_batch_launcher.sv | 156 +++++++++++++++
 tb/tb_fir_batch_launcher.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_batch_launcher.sv
// Batch call sequencer in front of the fir HLS component: issues one call per index,
// collects returns in order and streams index-tagged results through a FWFT FIFO.
module fir_batch_launcher #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cfg_go,
   input  logic [63:0]      cfg_base,
   input  logic [CNT_W-1:0] cfg_count,
   output logic             cfg_busy,
   output logic             cfg_done,
   output logic             fir_start,
   input  logic             fir_busy,
   output logic [63:0]      fir_d_i,
   output logic [63:0]      fir_idx,
   input  logic             fir_done,
   output logic             fir_stall,
   input  logic [31:0]      fir_returndata,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_data,
   output logic [CNT_W-1:0] res_idx
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [63:0]      r_base;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_issued;
   logic [CNT_W-1:0] r_returned;
   logic [CNT_W-1:0] r_mem_idx  [DEPTH];
   logic [31:0]      r_mem_data [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_occ;
   logic [AW:0]      w_occ_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic             w_go_ok;
   logic             w_call;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic [CNT_W:0]   w_credit_used;

   assign w_full  = (r_occ == (AW+1)'(DEPTH));
   assign w_empty = (r_occ == '0);
   assign w_go_ok = (r_state == S_IDLE) && cfg_go && (cfg_count != '0);

   // Outstanding calls plus buffered results must fit in the FIFO, so a return is never stalled.
   assign w_credit_used = {1'b0, r_issued - r_returned} + (CNT_W+1)'(r_occ);
   assign fir_start     = (r_state == S_RUN) && (r_issued < r_count) &&
                          (w_credit_used < (CNT_W+1)'(DEPTH));

   assign w_call = fir_start && !fir_busy;
   assign w_push = fir_done && !w_full;
   assign w_pop  = !w_empty && res_ready;

   always_comb begin
      w_occ_nxt = r_occ;
      if (w_push && !w_pop) begin
         w_occ_nxt = r_occ + (AW+1)'(1);
      end else if (!w_push && w_pop) begin
         w_occ_nxt = r_occ - (AW+1)'(1);
      end
   end

   // Drain exit looks at post-pop occupancy so done follows the final pop by one cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (cfg_go) begin
               if (cfg_count != '0) begin
                  w_state_nxt = S_RUN;
               end else begin
                  w_done_nxt = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (r_issued == r_count) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if ((r_returned == r_count) && (w_occ_nxt == '0)) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_done     <= 1'b0;
         r_base     <= '0;
         r_count    <= '0;
         r_issued   <= '0;
         r_returned <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_occ      <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_done_nxt;
         r_occ   <= w_occ_nxt;
         if (w_go_ok) begin
            r_base     <= cfg_base;
            r_count    <= cfg_count;
            r_issued   <= '0;
            r_returned <= '0;
         end else begin
            if (w_call) begin
               r_issued <= r_issued + CNT_W'(1);
            end
            if (w_push) begin
               r_returned <= r_returned + CNT_W'(1);
            end
         end
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem_data[r_wptr] <= fir_returndata;
         r_mem_idx[r_wptr]  <= r_returned;
      end
   end

   assign cfg_busy  = (r_state != S_IDLE);
   assign cfg_done  = r_done;
   assign fir_d_i   = r_base;
   assign fir_idx   = 64'(r_issued);
   assign fir_stall = w_full;
   assign res_valid = !w_empty;
   assign res_data  = w_empty ? '0 : r_mem_data[r_rptr];
   assign res_idx   = w_empty ? '0 : r_mem_idx[r_rptr];

endmodule

// File: tb/tb_fir_batch_launcher.sv
// Bench for fir_batch_launcher: a latency-configurable fir component model, a result
// monitor, and scenario tasks comparing the result stream against per-index expectations.
module tb_fir_batch_launcher;
   localparam int DEPTH = 4;
   localparam int CNT_W = 16;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             cfg_go = 1'b0;
   logic [63:0]      cfg_base = '0;
   logic [CNT_W-1:0] cfg_count = '0;
   logic             cfg_busy, cfg_done, fir_start, fir_stall, res_valid;
   logic             fir_busy = 1'b0;
   logic             fir_done = 1'b0;
   logic [31:0]      fir_returndata = '0;
   logic             res_ready = 1'b1;
   logic [63:0]      fir_d_i, fir_idx;
   logic [31:0]      res_data;
   logic [CNT_W-1:0] res_idx;

   fir_batch_launcher #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset), .cfg_go(cfg_go), .cfg_base(cfg_base), .cfg_count(cfg_count),
      .cfg_busy(cfg_busy), .cfg_done(cfg_done), .fir_start(fir_start), .fir_busy(fir_busy),
      .fir_d_i(fir_d_i), .fir_idx(fir_idx), .fir_done(fir_done), .fir_stall(fir_stall),
      .fir_returndata(fir_returndata), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_idx(res_idx)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int lat = 5;
   int busy_mode = 0;
   int ready_mode = 1;

   typedef struct { logic [63:0] base; logic [63:0] idx; int due; } pend_t;
   pend_t            pend_q[$];
   logic [63:0]      call_idx_q[$];
   logic [63:0]      call_base_q[$];
   int               call_cyc_q[$];
   logic [CNT_W-1:0] got_idx_q[$];
   logic [31:0]      got_data_q[$];
   int               done_cnt = 0;
   int               popped = 0;
   int               max_inflight = 0;
   int               hold_viol = 0;
   bit               start_seen = 0;
   bit               busy_seen = 0;
   bit               hold_pend = 0;
   logic [63:0]      hold_idx = '0;

   // The value the fir component returns for a call on buffer b at index i.
   function automatic logic [31:0] fmodel(input logic [63:0] b, input logic [63:0] i);
      return b[31:0] ^ b[63:32] ^ (i[31:0] * 32'h9E3779B1 + 32'h0123_4567);
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         pend_q.delete();
         hold_pend = 0;
      end else begin
         cyc++;
         if (hold_pend && (!fir_start || fir_idx != hold_idx)) hold_viol++;
         hold_pend = fir_start && fir_busy;
         hold_idx  = fir_idx;
         if (fir_start && !fir_busy) begin
            pend_q.push_back('{base: fir_d_i, idx: fir_idx, due: cyc + lat});
            call_idx_q.push_back(fir_idx);
            call_base_q.push_back(fir_d_i);
            call_cyc_q.push_back(cyc);
         end
         if (fir_done && !fir_stall && pend_q.size() > 0) pend_q.delete(0);
         if (res_valid && res_ready) begin
            got_idx_q.push_back(res_idx);
            got_data_q.push_back(res_data);
            popped++;
         end
         if (cfg_done) done_cnt++;
         if (fir_start) start_seen = 1;
         if (cfg_busy) busy_seen = 1;
         if (call_idx_q.size() - popped > max_inflight) max_inflight = call_idx_q.size() - popped;
      end
   end

   always @(negedge clock) begin
      if (reset || pend_q.size() == 0) begin
         fir_done = 1'b0;
         fir_returndata = '0;
      end else if (pend_q[0].due <= cyc + 1) begin
         fir_done = 1'b1;
         fir_returndata = fmodel(pend_q[0].base, pend_q[0].idx);
      end else begin
         fir_done = 1'b0;
      end
      case (busy_mode)
         0: fir_busy = 1'b0;
         1: fir_busy = 1'b1;
         default: fir_busy = ($urandom_range(0, 99) < 30);
      endcase
      case (ready_mode)
         0: res_ready = 1'b0;
         1: res_ready = 1'b1;
         default: res_ready = ($urandom_range(0, 99) < 60);
      endcase
   end

   task automatic clear_mon();
      call_idx_q.delete(); call_base_q.delete(); call_cyc_q.delete();
      got_idx_q.delete(); got_data_q.delete();
      done_cnt = 0; popped = 0; max_inflight = 0; hold_viol = 0;
      start_seen = 0; busy_seen = 0;
   endtask

   task automatic set_modes(input int b, input int r);
      @(posedge clock); #1;
      busy_mode = b;
      ready_mode = r;
   endtask

   task automatic start_batch(input logic [63:0] b, input logic [CNT_W-1:0] n);
      clear_mon();
      @(negedge clock);
      cfg_go = 1'b1; cfg_base = b; cfg_count = n;
      @(negedge clock);
      cfg_go = 1'b0; cfg_base = {$urandom, $urandom}; cfg_count = CNT_W'($urandom);
   endtask

   task automatic wait_done(input int budget, output bit to);
      to = 1'b1;
      for (int k = 0; k < budget; k++) begin
         @(negedge clock);
         if (done_cnt > 0) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clock);
      checks++; if (cfg_busy !== 1'b0) begin failures++; $display("FAIL rst_cfg_busy got=%0b exp=0", cfg_busy); end
      checks++; if (cfg_done !== 1'b0) begin failures++; $display("FAIL rst_cfg_done got=%0b exp=0", cfg_done); end
      checks++; if (fir_start !== 1'b0) begin failures++; $display("FAIL rst_fir_start got=%0b exp=0", fir_start); end
      checks++; if (fir_stall !== 1'b0) begin failures++; $display("FAIL rst_fir_stall got=%0b exp=0", fir_stall); end
      checks++; if (fir_d_i !== 64'd0) begin failures++; $display("FAIL rst_fir_d_i got=%0h exp=0", fir_d_i); end
      checks++; if (fir_idx !== 64'd0) begin failures++; $display("FAIL rst_fir_idx got=%0h exp=0", fir_idx); end
      checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rst_res_valid got=%0b exp=0", res_valid); end
      checks++; if (res_data !== 32'd0) begin failures++; $display("FAIL rst_res_data got=%0h exp=0", res_data); end
      checks++; if (res_idx !== '0) begin failures++; $display("FAIL rst_res_idx got=%0h exp=0", res_idx); end
      reset = 1'b0;
      @(negedge clock);
      checks++; if (cfg_busy !== 1'b0) begin failures++; $display("FAIL rst_idle_busy got=%0b exp=0", cfg_busy); end
   endtask

   task automatic test_basic();
      bit to;
      lat = 5;
      set_modes(0, 1);
      start_batch(64'h1000, 3);
      checks++; if (cfg_busy !== 1'b1) begin failures++; $display("FAIL basic_busy_c1 got=%0b exp=1", cfg_busy); end
      checks++; if (fir_start !== 1'b1) begin failures++; $display("FAIL basic_start_c1 got=%0b exp=1", fir_start); end
      wait_done(100, to);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%0b exp=0", to); end
      checks++; if (call_idx_q.size() !== 3) begin failures++; $display("FAIL basic_calls got=%0d exp=3", call_idx_q.size()); end
      for (int i = 0; i < call_idx_q.size() && i < 3; i++) begin
         checks++;
         if (call_idx_q[i] !== 64'(i) || call_base_q[i] !== 64'h1000 || call_cyc_q[i] !== call_cyc_q[0] + i) begin
            failures++;
            $display("FAIL basic_call%0d got idx=%0h base=%0h cyc=%0d exp idx=%0h base=1000 cyc=%0d",
                     i, call_idx_q[i], call_base_q[i], call_cyc_q[i], i, call_cyc_q[0] + i);
         end
      end
      checks++; if (got_idx_q.size() !== 3) begin failures++; $display("FAIL basic_results got=%0d exp=3", got_idx_q.size()); end
      for (int i = 0; i < got_idx_q.size() && i < 3; i++) begin
         checks++;
         if (got_idx_q[i] !== CNT_W'(i) || got_data_q[i] !== fmodel(64'h1000, 64'(i))) begin
            failures++;
            $display("FAIL basic_res%0d got idx=%0d data=%0h exp idx=%0d data=%0h",
                     i, got_idx_q[i], got_data_q[i], i, fmodel(64'h1000, 64'(i)));
         end
      end
      repeat (3) @(negedge clock);
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt); end
      checks++; if (cfg_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%0b exp=0", cfg_busy); end
   endtask

   task automatic test_zero_count();
      set_modes(0, 1);
      start_batch(64'hDEAD_0000, 0);
      checks++; if (cfg_done !== 1'b1) begin failures++; $display("FAIL zero_done_c1 got=%0b exp=1", cfg_done); end
      checks++; if (cfg_busy !== 1'b0) begin failures++; $display("FAIL zero_busy_c1 got=%0b exp=0", cfg_busy); end
      @(negedge clock);
      checks++; if (cfg_done !== 1'b0) begin failures++; $display("FAIL zero_done_c2 got=%0b exp=0", cfg_done); end
      repeat (5) @(negedge clock);
      checks++; if (start_seen !== 1'b0) begin failures++; $display("FAIL zero_start_seen got=%0b exp=0", start_seen); end
      checks++; if (busy_seen !== 1'b0) begin failures++; $display("FAIL zero_busy_seen got=%0b exp=0", busy_seen); end
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL zero_done_pulses got=%0d exp=1", done_cnt); end
   endtask

   task automatic test_busy_hold();
      bit to;
      int exp_cyc;
      lat = 3;
      set_modes(1, 1);
      start_batch(64'h0000_0042_0000_2000, 2);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (fir_start !== 1'b1 || fir_idx !== 64'd0 || call_idx_q.size() !== 0) begin
            failures++;
            $display("FAIL busy_hold_c%0d got start=%0b idx=%0h calls=%0d exp start=1 idx=0 calls=0",
                     k, fir_start, fir_idx, call_idx_q.size());
         end
         @(negedge clock);
      end
      set_modes(0, 1);
      exp_cyc = cyc + 1;
      @(posedge clock); #1;
      checks++; if (call_idx_q.size() !== 1) begin failures++; $display("FAIL busy_release_calls got=%0d exp=1", call_idx_q.size()); end
      checks++;
      if (call_cyc_q.size() == 0 || call_cyc_q[0] !== exp_cyc) begin
         failures++;
         $display("FAIL busy_release_cycle got=%0d exp=%0d", (call_cyc_q.size() == 0) ? -1 : call_cyc_q[0], exp_cyc);
      end
      wait_done(100, to);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL busy_timeout got=%0b exp=0", to); end
      checks++; if (hold_viol !== 0) begin failures++; $display("FAIL busy_hold_stable got=%0d exp=0", hold_viol); end
      checks++; if (got_idx_q.size() !== 2) begin failures++; $display("FAIL busy_results got=%0d exp=2", got_idx_q.size()); end
   endtask

   task automatic test_backpressure();
      bit to;
      logic [63:0] b;
      b = 64'h0000_0000_0003_0000;
      lat = 3;
      set_modes(0, 0);
      start_batch(b, 10);
      repeat (30) @(negedge clock);
      checks++; if (call_idx_q.size() !== 4) begin failures++; $display("FAIL bp_calls got=%0d exp=4", call_idx_q.size()); end
      checks++; if (fir_start !== 1'b0) begin failures++; $display("FAIL bp_start got=%0b exp=0", fir_start); end
      checks++; if (fir_stall !== 1'b1) begin failures++; $display("FAIL bp_stall got=%0b exp=1", fir_stall); end
      checks++;
      if (res_valid !== 1'b1 || res_idx !== '0 || res_data !== fmodel(b, 0)) begin
         failures++;
         $display("FAIL bp_head got v=%0b idx=%0d data=%0h exp v=1 idx=0 data=%0h", res_valid, res_idx, res_data, fmodel(b, 0));
      end
      set_modes(0, 1);
      wait_done(200, to);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL bp_timeout got=%0b exp=0", to); end
      checks++; if (got_idx_q.size() !== 10) begin failures++; $display("FAIL bp_results got=%0d exp=10", got_idx_q.size()); end
      for (int i = 0; i < got_idx_q.size() && i < 10; i++) begin
         checks++;
         if (got_idx_q[i] !== CNT_W'(i) || got_data_q[i] !== fmodel(b, 64'(i))) begin
            failures++;
            $display("FAIL bp_res%0d got idx=%0d data=%0h exp idx=%0d data=%0h",
                     i, got_idx_q[i], got_data_q[i], i, fmodel(b, 64'(i)));
         end
      end
      checks++; if (max_inflight > DEPTH) begin failures++; $display("FAIL bp_credit got=%0d exp<=%0d", max_inflight, DEPTH); end
   endtask

   task automatic test_go_ignored();
      bit to;
      int bad;
      logic [63:0] a;
      a = 64'h0000_0000_0000_5000;
      lat = 4;
      set_modes(0, 1);
      start_batch(a, 2);
      @(negedge clock);
      cfg_go = 1'b1; cfg_base = 64'h0000_0000_0000_9000; cfg_count = 7;
      @(negedge clock);
      cfg_go = 1'b0;
      wait_done(100, to);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL ign_timeout got=%0b exp=0", to); end
      checks++; if (got_idx_q.size() !== 2) begin failures++; $display("FAIL ign_results got=%0d exp=2", got_idx_q.size()); end
      bad = 0;
      for (int i = 0; i < got_idx_q.size(); i++)
         if (got_idx_q[i] !== CNT_W'(i) || got_data_q[i] !== fmodel(a, 64'(i))) bad++;
      for (int i = 0; i < call_base_q.size(); i++)
         if (call_base_q[i] !== a) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL ign_values got=%0d bad exp=0", bad); end
      repeat (10) @(negedge clock);
      checks++; if (call_idx_q.size() !== 2) begin failures++; $display("FAIL ign_calls got=%0d exp=2", call_idx_q.size()); end
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL ign_done_pulses got=%0d exp=1", done_cnt); end
      checks++; if (cfg_busy !== 1'b0) begin failures++; $display("FAIL ign_busy_after got=%0b exp=0", cfg_busy); end
   endtask

   task automatic test_random();
      bit to;
      int n;
      int bad;
      logic [63:0] b;
      set_modes(2, 2);
      for (int t = 0; t < 5; t++) begin
         n = $urandom_range(1, 12);
         b = {$urandom, $urandom};
         lat = $urandom_range(1, 6);
         start_batch(b, CNT_W'(n));
         wait_done(800, to);
         checks++; if (to !== 1'b0) begin failures++; $display("FAIL rand%0d_timeout got=%0b exp=0", t, to); end
         checks++; if (got_idx_q.size() !== n) begin failures++; $display("FAIL rand%0d_results got=%0d exp=%0d", t, got_idx_q.size(), n); end
         bad = 0;
         for (int i = 0; i < got_idx_q.size(); i++)
            if (got_idx_q[i] !== CNT_W'(i) || got_data_q[i] !== fmodel(b, 64'(i))) bad++;
         checks++; if (bad !== 0) begin failures++; $display("FAIL rand%0d_values got=%0d bad exp=0", t, bad); end
         bad = 0;
         for (int i = 0; i < call_idx_q.size(); i++)
            if (call_idx_q[i] !== 64'(i) || call_base_q[i] !== b) bad++;
         checks++; if (bad !== 0 || call_idx_q.size() !== n) begin failures++; $display("FAIL rand%0d_calls got=%0d calls %0d bad exp=%0d calls 0 bad", t, call_idx_q.size(), bad, n); end
         checks++; if (max_inflight > DEPTH) begin failures++; $display("FAIL rand%0d_credit got=%0d exp<=%0d", t, max_inflight, DEPTH); end
         checks++; if (hold_viol !== 0) begin failures++; $display("FAIL rand%0d_hold got=%0d exp=0", t, hold_viol); end
         repeat (2) @(negedge clock);
         checks++; if (done_cnt !== 1) begin failures++; $display("FAIL rand%0d_done_pulses got=%0d exp=1", t, done_cnt); end
      end
      set_modes(0, 1);
   endtask

   task automatic test_reset_mid();
      bit to;
      bit seen;
      logic [63:0] b;
      lat = 4;
      set_modes(0, 1);
      start_batch(64'h0000_0007_0000_7000, 6);
      seen = 0;
      for (int k = 0; k < 30; k++) begin
         if (call_idx_q.size() == 2) begin
            seen = 1;
            break;
         end
         @(negedge clock);
      end
      checks++; if (seen !== 1'b1) begin failures++; $display("FAIL rmid_two_calls got=%0d exp=2", call_idx_q.size()); end
      reset = 1'b1;
      #1;
      checks++; if (cfg_busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%0b exp=0", cfg_busy); end
      checks++; if (fir_start !== 1'b0) begin failures++; $display("FAIL rmid_start got=%0b exp=0", fir_start); end
      checks++; if (fir_idx !== 64'd0) begin failures++; $display("FAIL rmid_idx got=%0h exp=0", fir_idx); end
      checks++; if (fir_d_i !== 64'd0) begin failures++; $display("FAIL rmid_d_i got=%0h exp=0", fir_d_i); end
      checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rmid_res_valid got=%0b exp=0", res_valid); end
      checks++; if (res_idx !== '0) begin failures++; $display("FAIL rmid_res_idx got=%0h exp=0", res_idx); end
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      b = 64'h0000_0000_0000_B000;
      start_batch(b, 2);
      wait_done(100, to);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL rmid_timeout got=%0b exp=0", to); end
      checks++; if (got_idx_q.size() !== 2) begin failures++; $display("FAIL rmid_results got=%0d exp=2", got_idx_q.size()); end
      for (int i = 0; i < got_idx_q.size() && i < 2; i++) begin
         checks++;
         if (got_idx_q[i] !== CNT_W'(i) || got_data_q[i] !== fmodel(b, 64'(i))) begin
            failures++;
            $display("FAIL rmid_res%0d got idx=%0d data=%0h exp idx=%0d data=%0h",
                     i, got_idx_q[i], got_data_q[i], i, fmodel(b, 64'(i)));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_count();
      test_busy_hold();
      test_backpressure();
      test_go_ignored();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
